// File: rtl/cbfp_scaler.sv
// ----------------------------------------------------------------------------
// cbfp_scaler
// Convergent block-floating-point normaliser for the FFT datapath. A block of
// buffer_depth samples arrives as array_num rows of array_size samples, one
// row per valid clock. Each sample's count of redundant sign bits is taken,
// the smallest count in a row is kept in zero_cnt, and the smallest count of
// the whole block becomes a common left shift. The buffered block is then
// replayed row by row, shifted left by that amount and truncated so that only
// dout_size significant bits remain (sign-extended back to din_size).
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous reset, active high (1 = reset)
//   valid_in   din_re_p carries a valid row this cycle
//   din_re_p   input row, array_size signed samples of din_size bits
//   dout_re_p  normalised output row, dout_size-bit values sign-extended
//   zero_cnt   registered minimum sign-bit count of each row of the block
//   valid_out  dout_re_p carries a valid output row
// ----------------------------------------------------------------------------
module cbfp_scaler #(
   parameter int array_size   = 16,
   parameter int din_size     = 23,
   parameter int dout_size    = 11,
   parameter int buffer_depth = 64,
   parameter int array_num    = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       valid_in,
   input  logic signed [din_size-1:0] din_re_p  [array_size],
   output logic signed [din_size-1:0] dout_re_p [array_size],
   output logic        [din_size-1:0] zero_cnt  [array_num],
   output logic                       valid_out
);

   // Width of a sign-bit count (holds 0..din_size-1) and of a row pointer.
   localparam int CW   = $clog2(din_size);
   localparam int RW   = (array_num > 1) ? $clog2(array_num) : 1;
   localparam int ROWS = buffer_depth / array_size;
   localparam int SHR  = din_size - dout_size;
   localparam logic [RW-1:0] LAST_ROW = RW'(array_num - 1);

   typedef enum logic {
      ST_IDLE,
      ST_READ
   } state_t;

   state_t state_q, state_d;

   logic [RW-1:0] wr_row_q;
   logic [RW-1:0] rd_row_q;
   logic [CW-1:0] shift_q;
   logic [CW-1:0] cnt_q [array_num];

   logic signed [din_size-1:0] buf_mem [ROWS][array_size];

   logic [CW-1:0]              lane_cnt [array_size];
   logic [CW-1:0]              row_min;
   logic [CW-1:0]              block_min;
   logic                       block_done;
   logic signed [din_size-1:0] scaled [array_size];

   // Counts how many bits directly below the MSB repeat the MSB. The run
   // flag drops at the first differing bit so later matches are ignored.
   function automatic logic [CW-1:0] sign_count(input logic signed [din_size-1:0] x);
      logic          run;
      logic [CW-1:0] cnt;
      run = 1'b1;
      cnt = '0;
      for (int b = din_size - 2; b >= 0; b--) begin
         if (run && (x[b] == x[din_size-1])) begin
            cnt = cnt + 1'b1;
         end else begin
            run = 1'b0;
         end
      end
      return cnt;
   endfunction

   // Sign-bit count of every lane and the smallest of them for this row.
   always_comb begin
      for (int i = 0; i < array_size; i++) begin
         lane_cnt[i] = sign_count(din_re_p[i]);
      end
      row_min = lane_cnt[0];
      for (int i = 1; i < array_size; i++) begin
         if (lane_cnt[i] < row_min) begin
            row_min = lane_cnt[i];
         end
      end
   end

   // The block's shift must include the last row, which is not registered
   // yet when the block completes, so it is folded in straight from row_min.
   always_comb begin
      block_done = valid_in && (wr_row_q == LAST_ROW);
      block_min  = row_min;
      for (int k = 0; k < array_num - 1; k++) begin
         if (cnt_q[k] < block_min) begin
            block_min = cnt_q[k];
         end
      end
   end

   // Readout control: a completed block starts a readout of array_num rows.
   // A block that completes exactly as the previous readout finishes its
   // last row keeps the FSM in ST_READ so the next readout follows seamlessly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (block_done) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if ((rd_row_q == LAST_ROW) && !block_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Normalise the row being read out. The shift never exceeds any sample's
   // sign-bit count, so the left shift cannot overflow; the arithmetic right
   // shift then keeps dout_size significant bits, truncating the rest.
   always_comb begin
      for (int i = 0; i < array_size; i++) begin
         scaled[i] = (buf_mem[rd_row_q][i] <<< shift_q) >>> SHR;
      end
   end

   // Row buffer. Reads happen through the registered rd_row_q, so a row being
   // overwritten in the same cycle still returns its old contents.
   always_ff @(posedge clk) begin
      if (valid_in && !rstn) begin
         for (int i = 0; i < array_size; i++) begin
            buf_mem[wr_row_q][i] <= din_re_p[i];
         end
      end
   end

   // Pointers, per-row counts, block shift and output registers. The shift is
   // only updated on block completion so a running readout keeps its own.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q   <= ST_IDLE;
         wr_row_q  <= '0;
         rd_row_q  <= '0;
         shift_q   <= '0;
         valid_out <= 1'b0;
         for (int k = 0; k < array_num; k++) begin
            cnt_q[k] <= '0;
         end
         for (int i = 0; i < array_size; i++) begin
            dout_re_p[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (valid_in) begin
            cnt_q[wr_row_q] <= row_min;
            wr_row_q        <= (wr_row_q == LAST_ROW) ? '0 : wr_row_q + 1'b1;
         end
         if (block_done) begin
            shift_q <= block_min;
         end
         if (state_q == ST_READ) begin
            rd_row_q <= (rd_row_q == LAST_ROW) ? '0 : rd_row_q + 1'b1;
         end
         valid_out <= (state_q == ST_READ);
         for (int i = 0; i < array_size; i++) begin
            dout_re_p[i] <= (state_q == ST_READ) ? scaled[i] : '0;
         end
      end
   end

   // The per-row counts are kept narrow internally and widened for the port.
   always_comb begin
      for (int k = 0; k < array_num; k++) begin
         zero_cnt[k] = din_size'(cnt_q[k]);
      end
   end

endmodule

// File: tb/tb_cbfp_scaler.sv
// ----------------------------------------------------------------------------
// tb_cbfp_scaler
// Directed and randomised bench for cbfp_scaler. A reference model computes
// sign-bit counts and scaled outputs with plain integer arithmetic and keeps a
// queue of expected output rows; every cycle the outputs are compared.
// ----------------------------------------------------------------------------
module tb_cbfp_scaler;

   localparam int N    = 16;
   localparam int DW   = 23;
   localparam int OW   = 11;
   localparam int ROWS = 4;
   localparam int MAXP = (1 << (DW - 1)) - 1;

   typedef int row_t [N];

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 valid_in;
   logic signed [DW-1:0] din  [N];
   logic signed [DW-1:0] dout [N];
   logic        [DW-1:0] zcnt [ROWS];
   logic                 valid_out;

   int total = 0;
   int bad   = 0;

   int mbuf [ROWS][N];
   int mcnt [ROWS];
   int mw;
   int exp_q [$];
   int cur_exp [N];
   bit cur_valid;

   cbfp_scaler dut (
      .clk       (clk),
      .rstn      (rstn),
      .valid_in  (valid_in),
      .din_re_p  (din),
      .dout_re_p (dout),
      .zero_cnt  (zcnt),
      .valid_out (valid_out)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Largest k such that x still fits in DW-k bits as a signed number.
   function automatic int sign_bits(input int x);
      for (int k = DW - 1; k >= 0; k--) begin
         int half;
         half = 1 << (DW - 1 - k);
         if (x >= -half && x < half) return k;
      end
      return 0;
   endfunction

   function automatic row_t const_row(input int v);
      row_t r;
      foreach (r[i]) r[i] = v;
      return r;
   endfunction

   // Random signed samples whose magnitudes cluster around a random width,
   // so blocks exercise a wide spread of shift amounts.
   function automatic row_t rand_row(input int base);
      row_t r;
      foreach (r[i]) begin
         int w;
         int v;
         w = base - int'($urandom_range(0, 3));
         if (w < 1) w = 1;
         v = int'($urandom) & ((1 << w) - 1);
         if (((v >> (w - 1)) & 1) == 1) v = v - (1 << w);
         r[i] = v;
      end
      return r;
   endfunction

   // Advance the model by one clock edge: release the row due at this edge,
   // then absorb the input row and queue a whole block once it completes.
   task automatic modelEdge(input bit rst, input bit vld, input row_t row);
      if (rst) begin
         exp_q.delete();
         mw        = 0;
         cur_valid = 1'b0;
         foreach (mcnt[k]) mcnt[k] = 0;
         foreach (cur_exp[i]) cur_exp[i] = 0;
      end else begin
         if (exp_q.size() >= N) begin
            cur_valid = 1'b1;
            foreach (cur_exp[i]) cur_exp[i] = exp_q.pop_front();
         end else begin
            cur_valid = 1'b0;
            foreach (cur_exp[i]) cur_exp[i] = 0;
         end
         if (vld) begin
            int m;
            m = DW;
            foreach (row[i]) begin
               mbuf[mw][i] = row[i];
               if (sign_bits(row[i]) < m) m = sign_bits(row[i]);
            end
            mcnt[mw] = m;
            if (mw == ROWS - 1) begin
               int sh;
               sh = DW;
               foreach (mcnt[k]) if (mcnt[k] < sh) sh = mcnt[k];
               for (int r = 0; r < ROWS; r++) begin
                  for (int i = 0; i < N; i++) begin
                     longint scaled;
                     scaled = (longint'(mbuf[r][i]) * (longint'(1) << sh)) >>> (DW - OW);
                     exp_q.push_back(int'(scaled));
                  end
               end
            end
            mw = (mw + 1) % ROWS;
         end
      end
   endtask

   task automatic checkOutput();
      total++;
      assert (valid_out === cur_valid) else begin
         bad++;
         $error("[TB] FAIL valid_out observed=%0b expected=%0b", valid_out, cur_valid);
      end
      for (int i = 0; i < N; i++) begin
         logic signed [DW-1:0] e;
         e = DW'(cur_exp[i]);
         total++;
         assert (dout[i] === e) else begin
            bad++;
            $error("[TB] FAIL dout[%0d] observed=%0d expected=%0d", i, dout[i], e);
         end
      end
      for (int k = 0; k < ROWS; k++) begin
         logic [DW-1:0] e;
         e = DW'(mcnt[k]);
         total++;
         assert (zcnt[k] === e) else begin
            bad++;
            $error("[TB] FAIL zero_cnt[%0d] observed=%0d expected=%0d", k, zcnt[k], e);
         end
      end
   endtask

   // One clock cycle: drive on the falling edge, let the rising edge act,
   // then compare on the next falling edge.
   task automatic applyStimulus(input bit rst, input bit vld, input row_t row);
      rstn     = rst;
      valid_in = vld;
      foreach (din[i]) din[i] = DW'(row[i]);
      @(posedge clk);
      modelEdge(rst, vld, row);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, const_row(0));
   endtask

   task automatic sendBlock(input int v);
      repeat (ROWS) applyStimulus(1'b0, 1'b1, const_row(v));
   endtask

   initial begin
      row_t peak;

      rstn     = 1'b1;
      valid_in = 1'b0;
      foreach (din[i]) din[i] = '0;
      @(negedge clk);

      $display("[TB] reset");
      repeat (3) applyStimulus(1'b1, 1'b0, const_row(0));
      idle(1);

      $display("[TB] uniform block of ones");
      sendBlock(1);
      idle(5);

      $display("[TB] single peak sets the shift");
      peak    = const_row(1);
      peak[0] = MAXP;
      applyStimulus(1'b0, 1'b1, const_row(1));
      applyStimulus(1'b0, 1'b1, const_row(1));
      applyStimulus(1'b0, 1'b1, peak);
      applyStimulus(1'b0, 1'b1, const_row(1));
      idle(5);

      $display("[TB] all minus one, then all zero");
      sendBlock(-1);
      idle(5);
      sendBlock(0);
      idle(5);

      $display("[TB] gapped block");
      applyStimulus(1'b0, 1'b1, const_row(1));
      applyStimulus(1'b0, 1'b1, const_row(1));
      idle(4);
      applyStimulus(1'b0, 1'b1, const_row(1));
      applyStimulus(1'b0, 1'b1, const_row(1));
      idle(5);

      $display("[TB] back-to-back blocks");
      sendBlock(1);
      sendBlock(MAXP);
      idle(5);

      $display("[TB] reset in the middle of a block and of a readout");
      applyStimulus(1'b0, 1'b1, rand_row(12));
      applyStimulus(1'b0, 1'b1, rand_row(12));
      applyStimulus(1'b1, 1'b0, const_row(0));
      idle(2);
      sendBlock(-3);
      idle(2);
      applyStimulus(1'b1, 1'b0, const_row(0));
      idle(3);
      for (int r = 0; r < ROWS; r++) applyStimulus(1'b0, 1'b1, rand_row(9));
      idle(5);

      $display("[TB] randomised blocks with gaps");
      for (int b = 0; b < 30; b++) begin
         int base;
         base = int'($urandom_range(1, DW));
         for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            applyStimulus(1'b0, 1'b1, rand_row(base));
         end
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 6)));
      end
      idle(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
